// File: rtl/lidar_frame_rx_pkg.sv
// Shared definitions for the LIDAR frame receiver and its matching transmitter:
// header bytes, payload length, FSM state encodings and a payload-packing helper.
package lidar_frame_rx_pkg;

    localparam logic [7:0] HDR0        = 8'h55;
    localparam logic [7:0] HDR1        = 8'hAA;
    localparam int unsigned PAYLOAD_LEN = 6;
    localparam logic [2:0] LAST_IDX    = 3'(PAYLOAD_LEN - 1);

    typedef enum logic [1:0] {
        HUNT_H0 = 2'd0,
        HUNT_H1 = 2'd1,
        PAYLOAD = 2'd2,
        DONE    = 2'd3
    } frame_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Place payload byte idx into the 48-bit shadow; byte 0 lands in [47:40].
    function automatic logic [47:0] put_byte(input logic [47:0] shadow,
                                             input logic [2:0]  idx,
                                             input logic [7:0]  b);
        logic [47:0] r;
        r = shadow;
        case (idx)
            3'd0:    r[47:40] = b;
            3'd1:    r[39:32] = b;
            3'd2:    r[31:24] = b;
            3'd3:    r[23:16] = b;
            3'd4:    r[15:8]  = b;
            3'd5:    r[7:0]   = b;
            default: r        = shadow;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lidar_frame_rx_uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver with 2-flop input synchronizer.
// Ports:
//   clock        - system clock
//   reset        - asynchronous active-low reset
//   rxd          - asynchronous serial line, idle high, LSB first
//   byte_o       - last received byte (stable from byte_done_o until next byte's data)
//   byte_done_o  - one-cycle pulse after the stop bit has been sampled
//   byte_err_o   - valid with byte_done_o; high when the stop bit was 0
module uart_byte_rx
    import lidar_frame_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] byte_o,
    output logic       byte_done_o,
    output logic       byte_err_o
);

    localparam int unsigned CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic          sync1_q, sync2_q, prev_q;
    rx_state_e     st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    // Input synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Bit-timing state, counters, shifter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_q    <= RX_IDLE;
            cnt_q   <= {CW{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: start edge, mid-start check, 8 data samples, stop sample.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (st_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    st_d  = RX_START;
                    cnt_d = {CW{1'b0}};
                end else begin
                    st_d  = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = {CW{1'b0}};
                    bit_d = 3'd0;
                    // A line that is high again at mid-start was only a glitch.
                    if (sync2_q) begin
                        st_d = RX_IDLE;
                    end else begin
                        st_d = RX_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = {CW{1'b0}};
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        st_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d  = {CW{1'b0}};
                    done_d = 1'b1;
                    err_d  = !sync2_q;
                    st_d   = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                st_d  = RX_IDLE;
                cnt_d = {CW{1'b0}};
            end
        endcase
    end

    assign byte_o      = shift_q;
    assign byte_done_o = done_q;
    assign byte_err_o  = err_q;

endmodule

// File: rtl/lidar_frame_rx.sv
// lidar_frame_rx: receives 55 AA <6 payload bytes> frames over UART.
// Ports:
//   clock       - system clock
//   reset       - asynchronous active-low reset
//   rxd         - asynchronous serial line, idle high, 8N1
//   data        - payload of the last good frame, byte 0 in [47:40]
//   frame_valid - one-cycle pulse when data has been updated
//   frame_error - one-cycle pulse when a frame was dropped (bad stop or timeout)
//   busy        - high whenever the frame FSM is outside HUNT_H0
module lidar_frame_rx
    import lidar_frame_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned TIMEOUT_CLKS = 2048
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rxd,
    output logic [47:0] data,
    output logic        frame_valid,
    output logic        frame_error,
    output logic        busy
);

    localparam int unsigned TW      = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CLKS);

    logic [7:0]   rx_byte_s;
    logic         rx_done_s, rx_err_s;
    frame_state_e state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic [47:0]  shadow_q, shadow_d;
    logic [47:0]  data_q, data_d;
    logic         fv_q, fv_d, fe_q, fe_d, busy_q, busy_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic         expired_s;

    uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
        .clock       (clock),
        .reset       (reset),
        .rxd         (rxd),
        .byte_o      (rx_byte_s),
        .byte_done_o (rx_done_s),
        .byte_err_o  (rx_err_s)
    );

    // Frame FSM state, shadow payload, timeout counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= HUNT_H0;
            idx_q    <= 3'd0;
            shadow_q <= 48'h0;
            data_q   <= 48'h0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
            busy_q   <= 1'b0;
            tmo_q    <= {TW{1'b0}};
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            fv_q     <= fv_d;
            fe_q     <= fe_d;
            busy_q   <= busy_d;
            tmo_q    <= tmo_d;
        end
    end

    // tmo_q holds the number of cycles elapsed since the last byte_done.
    assign expired_s = (tmo_q == TMO_LIM);

    // Frame FSM next state. data/frame_valid are loaded on the edge that
    // enters DONE, so they are visible exactly during the DONE cycle.
    // A byte_done is always examined before the timeout, so the byte wins a tie.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        fv_d     = 1'b0;
        fe_d     = 1'b0;
        tmo_d    = tmo_q + 1'b1;
        case (state_q)
            HUNT_H0: begin
                if (rx_done_s && !rx_err_s && (rx_byte_s == HDR0)) begin
                    state_d = HUNT_H1;
                end else begin
                    state_d = HUNT_H0;
                end
            end
            HUNT_H1: begin
                if (rx_done_s) begin
                    if (rx_err_s) begin
                        fe_d    = 1'b1;
                        state_d = HUNT_H0;
                    end else if (rx_byte_s == HDR1) begin
                        state_d = PAYLOAD;
                        idx_d   = 3'd0;
                    end else if (rx_byte_s == HDR0) begin
                        state_d = HUNT_H1;
                    end else begin
                        state_d = HUNT_H0;
                    end
                end else if (expired_s) begin
                    fe_d    = 1'b1;
                    state_d = HUNT_H0;
                end else begin
                    state_d = HUNT_H1;
                end
            end
            PAYLOAD: begin
                if (rx_done_s) begin
                    if (rx_err_s) begin
                        fe_d    = 1'b1;
                        state_d = HUNT_H0;
                    end else begin
                        shadow_d = put_byte(shadow_q, idx_q, rx_byte_s);
                        idx_d    = idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                            data_d  = put_byte(shadow_q, idx_q, rx_byte_s);
                            fv_d    = 1'b1;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end
                end else if (expired_s) begin
                    fe_d    = 1'b1;
                    state_d = HUNT_H0;
                end else begin
                    state_d = PAYLOAD;
                end
            end
            DONE: begin
                state_d = HUNT_H0;
            end
            default: begin
                state_d = HUNT_H0;
            end
        endcase
        // The counter restarts at every byte and only runs while a frame is open.
        if ((state_d == HUNT_H1) || (state_d == PAYLOAD)) begin
            if (rx_done_s) begin
                tmo_d = {{(TW-1){1'b0}}, 1'b1};
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = {TW{1'b0}};
        end
        busy_d = (state_d != HUNT_H0);
    end

    assign data        = data_q;
    assign frame_valid = fv_q;
    assign frame_error = fe_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_lidar_frame_rx.sv
// Directed testbench for lidar_frame_rx (CLKS_PER_BIT = 4, TIMEOUT_CLKS = 200).
// rxd is driven on falling edges; outputs are sampled on falling edges.
module tb_lidar_frame_rx;

    localparam int C   = 4;
    localparam int TMO = 200;
    // Start bit driven at cycle n0 -> 2 sync flops + edge register, half a bit
    // to the start check, 9 bits to the stop sample, byte_done one cycle later,
    // frame_valid one cycle after byte_done.
    localparam int FV_LAT = 4 + C / 2 + 9 * C;

    logic        clock;
    logic        reset;
    logic        rxd;
    logic [47:0] data;
    logic        frame_valid, frame_error, busy;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int fv_cnt  = 0;
    int fe_cnt  = 0;
    int both_cnt = 0;
    int last_fv_cyc = 0;
    int last_n0 = 0;
    int fv0, fe0;

    lidar_frame_rx #(.CLKS_PER_BIT(C), .TIMEOUT_CLKS(TMO)) dut (
        .clock       (clock),
        .reset       (reset),
        .rxd         (rxd),
        .data        (data),
        .frame_valid (frame_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (frame_valid) begin
            fv_cnt      <= fv_cnt + 1;
            last_fv_cyc <= cyc;
        end
        if (frame_error) fe_cnt <= fe_cnt + 1;
        if (frame_valid && frame_error) both_cnt <= both_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        last_n0 = cyc;
        rxd = 1'b0;
        repeat (C) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (C) @(negedge clock);
        end
        rxd = stop_bit;
        repeat (C) @(negedge clock);
        rxd = 1'b1;
    endtask

    // Header plus payload; an optional idle gap precedes payload byte gap_idx.
    task automatic send_frame(input logic [47:0] p, input int gap_idx, input int gap);
        logic [47:0] v;
        v = p;
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i == gap_idx) idle(gap);
            send_byte(v[47 - 8 * i -: 8], 1'b1);
        end
    endtask

    task automatic glitch();
        rxd = 1'b0;
        @(negedge clock);
        rxd = 1'b1;
    endtask

    task automatic mark();
        fv0 = fv_cnt;
        fe0 = fe_cnt;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        rxd   = 1'b1;
        repeat (5) @(negedge clock);
        check_val("rst_data", data, 48'h0);
        check_val("rst_fv", {47'h0, frame_valid}, 48'h0);
        check_val("rst_fe", {47'h0, frame_error}, 48'h0);
        check_val("rst_busy", {47'h0, busy}, 48'h0);
        reset = 1'b1;
        idle(10);

        // Glitch while idle: nothing happens.
        mark();
        glitch();
        idle(20);
        check_val("glitch_idle_busy", {47'h0, busy}, 48'h0);
        check_val("glitch_idle_fe", 48'(fe_cnt - fe0), 48'h0);

        // Basic frame and output latency.
        mark();
        send_frame(48'h123456789ABC, 99, 0);
        idle(10);
        check_val("f1_data", data, 48'h123456789ABC);
        check_val("f1_fv", 48'(fv_cnt - fv0), 48'h1);
        check_val("f1_lat", 48'(last_fv_cyc), 48'(last_n0 + FV_LAT));
        check_val("f1_fe", 48'(fe_cnt - fe0), 48'h0);
        check_val("f1_busy", {47'h0, busy}, 48'h0);

        // Resynchronisation on a noisy header.
        mark();
        send_byte(8'h00, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1);
        idle(10);
        check_val("resync_data", data, 48'h010203040506);
        check_val("resync_fv", 48'(fv_cnt - fv0), 48'h1);

        // Bad stop bit mid-payload drops the frame, data holds.
        mark();
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        idle(8);
        check_val("badstop_fe", 48'(fe_cnt - fe0), 48'h1);
        check_val("badstop_data", data, 48'h010203040506);
        check_val("badstop_busy", {47'h0, busy}, 48'h0);
        mark();
        send_frame(48'hC0FFEE123456, 99, 0);
        idle(10);
        check_val("after_bad_data", data, 48'hC0FFEE123456);
        check_val("after_bad_fv", 48'(fv_cnt - fv0), 48'h1);

        // Bad stop in HUNT_H0 is ignored, and a bad 0x55 does not open a frame.
        mark();
        send_byte(8'h55, 1'b0);
        idle(8);
        check_val("h0_err_fe", 48'(fe_cnt - fe0), 48'h0);
        check_val("h0_err_busy", {47'h0, busy}, 48'h0);

        // Idle timeout inside a frame.
        mark();
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h11, 1'b1);
        idle(2 * TMO);
        check_val("tmo_fe", 48'(fe_cnt - fe0), 48'h1);
        check_val("tmo_fv", 48'(fv_cnt - fv0), 48'h0);
        check_val("tmo_busy", {47'h0, busy}, 48'h0);
        check_val("tmo_data", data, 48'hC0FFEE123456);

        // byte_done spacing = 10*C + gap. Spacing TMO: byte wins the tie.
        mark();
        send_frame(48'h0A0B0C0D0E0F, 3, TMO - 10 * C);
        idle(10);
        check_val("tie_fv", 48'(fv_cnt - fv0), 48'h1);
        check_val("tie_fe", 48'(fe_cnt - fe0), 48'h0);
        check_val("tie_data", data, 48'h0A0B0C0D0E0F);

        // Spacing TMO+1: the timeout fires first.
        mark();
        send_frame(48'h313233343536, 3, TMO - 10 * C + 1);
        idle(10);
        check_val("over_fe", 48'(fe_cnt - fe0), 48'h1);
        check_val("over_fv", 48'(fv_cnt - fv0), 48'h0);
        check_val("over_data", data, 48'h0A0B0C0D0E0F);

        // Glitches inside a frame must not create bytes.
        mark();
        send_byte(8'h55, 1'b1);
        glitch();
        idle(10);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h07, 1'b1);
        glitch();
        idle(10);
        send_byte(8'h08, 1'b1);
        send_byte(8'h09, 1'b1);
        send_byte(8'h0A, 1'b1);
        send_byte(8'h0B, 1'b1);
        send_byte(8'h0C, 1'b1);
        idle(10);
        check_val("glitch_fr_data", data, 48'h0708090A0B0C);
        check_val("glitch_fr_fv", 48'(fv_cnt - fv0), 48'h1);
        check_val("glitch_fr_fe", 48'(fe_cnt - fe0), 48'h0);

        // Reset during payload byte 3.
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        rxd = 1'b0;
        repeat (6) @(negedge clock);
        reset = 1'b0;
        rxd   = 1'b1;
        @(negedge clock);
        check_val("midrst_data", data, 48'h0);
        check_val("midrst_fv", {47'h0, frame_valid}, 48'h0);
        check_val("midrst_fe", {47'h0, frame_error}, 48'h0);
        check_val("midrst_busy", {47'h0, busy}, 48'h0);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        idle(10);
        check_val("postrst_busy", {47'h0, busy}, 48'h0);
        mark();
        send_frame(48'hDEADBEEF0001, 99, 0);
        idle(10);
        check_val("postrst_data", data, 48'hDEADBEEF0001);
        check_val("postrst_fv", 48'(fv_cnt - fv0), 48'h1);
        check_val("postrst_fe", 48'(fe_cnt - fe0), 48'h0);

        check_val("fv_fe_overlap", 48'(both_cnt), 48'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
